// File: rtl/loader_pkg.sv
// Shared types for the UART program loader: FSM states, length width and byte/word types.
package loader_pkg;

  localparam int unsigned LEN_W = 16;

  typedef logic [7:0]       byte_t;
  typedef logic [15:0]      word_t;
  typedef logic [LEN_W-1:0] len_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    W_HI   = 3'd2,
    W_LO   = 3'd3,
    CSUM   = 3'd4,
    FINISH = 3'd5
  } state_t;

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte watchdog: counts enabled clocks since the last clear and flags when TIMEOUT_CLKS-1 is reached.
module loader_timeout #(
  parameter int unsigned TIMEOUT_CLKS = 1_000_000,
  localparam int unsigned CW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CLKS - 1);

  logic [CW-1:0] cnt;
  logic          at_last;

  assign at_last = (cnt == LAST);
  // A clear on the expiry clock wins, so a byte arriving just in time is never lost.
  assign expired = enable & ~clear & at_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !at_last) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_loader.sv
// Assembles UART bytes into a length-prefixed frame of 16-bit words written to instruction memory.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module uart_loader
  import loader_pkg::*;
#(
  parameter int unsigned        ADDR_W       = 16,
  parameter logic [ADDR_W-1:0]  BASE_ADDR    = '0,
  parameter int unsigned        TIMEOUT_CLKS = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              err,
  output state_t            dbg_state
);

`ifdef LOADER_CHECKSUM_EN
  localparam state_t AFTER_DATA = CSUM;
`else
  localparam state_t AFTER_DATA = FINISH;
`endif

  state_t state, state_d;
  logic   rdy_q;
  logic   stb;
  len_t   len;
  len_t   idx;
  byte_t  hi;
  byte_t  csum;
  logic   last_word;
  logic   tmo_clear;
  logic   tmo_en;
  logic   tmo_expired;

  // Receiver handshake: rx_data is valid while rx_ready is high; each rising edge
  // of rx_ready is exactly one byte. There is no back-pressure toward the receiver.
  assign stb       = rx_ready & ~rdy_q;
  assign last_word = ({1'b0, idx} + 17'd1) >= {1'b0, len};
  assign tmo_clear = stb | (state == IDLE);
  assign tmo_en    = (state != IDLE) && (state != FINISH);
  assign done      = (state == FINISH);
  assign dbg_state = state;

  loader_timeout #(
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmo_clear),
    .enable  (tmo_en),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:   if (stb) state_d = LEN_LO;
      LEN_LO: if (stb) state_d = ({len[15:8], rx_data} != '0) ? W_HI : AFTER_DATA;
      W_HI:   if (stb) state_d = W_LO;
      W_LO:   if (stb) state_d = last_word ? AFTER_DATA : W_HI;
      CSUM:   if (stb) state_d = FINISH;
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (tmo_expired) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q     <= 1'b1;
      len       <= '0;
      idx       <= '0;
      hi        <= '0;
      csum      <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      rdy_q  <= rx_ready;
      mem_we <= 1'b0;
      if (stb) begin
        case (state)
          IDLE: begin
            len[15:8] <= rx_data;
            err       <= 1'b0;
            busy      <= 1'b1;
            idx       <= '0;
            csum      <= rx_data;
          end
          LEN_LO: begin
            len[7:0] <= rx_data;
            csum     <= csum ^ rx_data;
          end
          W_HI: begin
            hi   <= rx_data;
            csum <= csum ^ rx_data;
          end
          W_LO: begin
            mem_we    <= 1'b1;
            mem_addr  <= BASE_ADDR + ADDR_W'(idx);
            mem_wdata <= {hi, rx_data};
            idx       <= idx + 16'd1;
            csum      <= csum ^ rx_data;
          end
          CSUM: begin
            if (rx_data != csum) err <= 1'b1;
          end
          default: ;
        endcase
      end
      if (state == FINISH) begin
        busy <= 1'b0;
      end
      if (tmo_expired) begin
        err  <= 1'b1;
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: instance a at BASE_ADDR 0, instance b at BASE_ADDR 0xFFFF.
module tb_uart_loader;
  import loader_pkg::*;

  localparam int TMO = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_rx_ready, a_mem_we, a_busy, a_done, a_err;
  logic [7:0]  a_rx_data;
  logic [15:0] a_mem_addr, a_mem_wdata;
  state_t      a_dbg_state;

  logic        b_rst, b_rx_ready, b_mem_we, b_busy, b_done, b_err;
  logic [7:0]  b_rx_data;
  logic [15:0] b_mem_addr, b_mem_wdata;
  state_t      b_dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int a_done_cnt = 0;
  int b_done_cnt = 0;
  int d0;
  logic [31:0] a_obs_q[$];
  logic [31:0] b_obs_q[$];
  logic [31:0] exp_q[$];

  uart_loader #(.ADDR_W(16), .BASE_ADDR(16'h0000), .TIMEOUT_CLKS(TMO)) dut_a (
    .clk(clk), .rst(a_rst), .rx_data(a_rx_data), .rx_ready(a_rx_ready),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_we(a_mem_we),
    .busy(a_busy), .done(a_done), .err(a_err), .dbg_state(a_dbg_state)
  );

  uart_loader #(.ADDR_W(16), .BASE_ADDR(16'hFFFF), .TIMEOUT_CLKS(TMO)) dut_b (
    .clk(clk), .rst(b_rst), .rx_data(b_rx_data), .rx_ready(b_rx_ready),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we),
    .busy(b_busy), .done(b_done), .err(b_err), .dbg_state(b_dbg_state)
  );

  // Write/done monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (a_mem_we === 1'b1) a_obs_q.push_back({a_mem_addr, a_mem_wdata});
    if (b_mem_we === 1'b1) b_obs_q.push_back({b_mem_addr, b_mem_wdata});
    if (a_done === 1'b1) a_done_cnt++;
    if (b_done === 1'b1) b_done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input bit to_b, input logic [7:0] b);
    @(posedge clk); #1;
    if (to_b) begin b_rx_data = b; b_rx_ready = 1'b1; end
    else      begin a_rx_data = b; a_rx_ready = 1'b1; end
    repeat (2) @(posedge clk);
    #1;
    if (to_b) b_rx_ready = 1'b0; else a_rx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_writes(input bit to_b, input string tag);
    logic [31:0] o;
    int n_obs;
    n_obs = to_b ? b_obs_q.size() : a_obs_q.size();
    check({tag, "_count"}, 32'(n_obs), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      if (to_b) begin
        if (b_obs_q.size() == 0) break;
        o = b_obs_q.pop_front();
      end else begin
        if (a_obs_q.size() == 0) break;
        o = a_obs_q.pop_front();
      end
      check({tag, "_write"}, o, exp_q.pop_front());
    end
    exp_q.delete();
    a_obs_q.delete();
    b_obs_q.delete();
  endtask

  initial begin
    a_rst = 1'b1; a_rx_ready = 1'b1; a_rx_data = 8'h00;
    b_rst = 1'b1; b_rx_ready = 1'b0; b_rx_data = 8'h00;

    // Reset state, with a_rx_ready already high.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_we", a_mem_we, 1'b0);
    check("rst_done", a_done, 1'b0);
    check("rst_busy", a_busy, 1'b0);
    check("rst_err", a_err, 1'b0);
    check("rst_addr", a_mem_addr, 16'h0000);
    check("rst_wdata", a_mem_wdata, 16'h0000);
    check("rst_state", a_dbg_state, IDLE);

    // rx_ready high through reset release is not a byte.
    @(posedge clk); #1;
    a_rst = 1'b0; b_rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("held_high_busy", a_busy, 1'b0);
    check("held_high_state", a_dbg_state, IDLE);
    a_rx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send(1'b0, 8'h00);
    check("one_byte_busy", a_busy, 1'b1);
    check("one_byte_state", a_dbg_state, LEN_LO);

    // len = 0: no writes, a single done.
    d0 = a_done_cnt;
    send(1'b0, 8'h00);
`ifdef LOADER_CHECKSUM_EN
    send(1'b0, 8'h00);
`endif
    check("len0_done", 32'(a_done_cnt), 32'(d0 + 1));
    check("len0_busy", a_busy, 1'b0);
    check("len0_err", a_err, 1'b0);
    check_writes(1'b0, "len0");

    // len = 2, words 0x1234, 0xABCD.
    d0 = a_done_cnt;
    send(1'b0, 8'h00); send(1'b0, 8'h02);
    send(1'b0, 8'h12); send(1'b0, 8'h34);
    check("len2_busy_mid", a_busy, 1'b1);
    send(1'b0, 8'hAB); send(1'b0, 8'hCD);
`ifdef LOADER_CHECKSUM_EN
    send(1'b0, 8'h42);
`endif
    exp_q.push_back(32'h0000_1234);
    exp_q.push_back(32'h0001_ABCD);
    check_writes(1'b0, "len2");
    check("len2_done", 32'(a_done_cnt), 32'(d0 + 1));
    check("len2_err", a_err, 1'b0);
    check("len2_busy", a_busy, 1'b0);
    check("len2_addr_hold", a_mem_addr, 16'h0001);
    check("len2_wdata_hold", a_mem_wdata, 16'hABCD);

    // Timeout after the two length bytes of a len = 3 frame.
    d0 = a_done_cnt;
    send(1'b0, 8'h00); send(1'b0, 8'h03);
    check("tmo_busy_before", a_busy, 1'b1);
    check("tmo_err_before", a_err, 1'b0);
    repeat (TMO + 20) @(posedge clk);
    #1;
    check("tmo_err", a_err, 1'b1);
    check("tmo_busy", a_busy, 1'b0);
    check("tmo_state", a_dbg_state, IDLE);
    check("tmo_no_done", 32'(a_done_cnt), 32'(d0));
    send(1'b0, 8'h00);
    check("tmo_err_cleared", a_err, 1'b0);
    check("tmo_new_busy", a_busy, 1'b1);
    send(1'b0, 8'h00);
`ifdef LOADER_CHECKSUM_EN
    send(1'b0, 8'h00);
`endif
    check("tmo_next_done", 32'(a_done_cnt), 32'(d0 + 1));
    check_writes(1'b0, "tmo");

`ifdef LOADER_CHECKSUM_EN
    // Checksum good then bad.
    d0 = a_done_cnt;
    send(1'b0, 8'h00); send(1'b0, 8'h01); send(1'b0, 8'h01); send(1'b0, 8'h02);
    send(1'b0, 8'h02);
    check("csum_ok_done", 32'(a_done_cnt), 32'(d0 + 1));
    check("csum_ok_err", a_err, 1'b0);
    exp_q.push_back(32'h0000_0102);
    check_writes(1'b0, "csum_ok");
    send(1'b0, 8'h00); send(1'b0, 8'h01); send(1'b0, 8'h01); send(1'b0, 8'h02);
    send(1'b0, 8'h03);
    check("csum_bad_done", 32'(a_done_cnt), 32'(d0 + 2));
    check("csum_bad_err", a_err, 1'b1);
    exp_q.push_back(32'h0000_0102);
    check_writes(1'b0, "csum_bad");
`endif

    // BASE_ADDR 0xFFFF: address wrap, then async reset mid-word.
    d0 = b_done_cnt;
    send(1'b1, 8'h00); send(1'b1, 8'h02);
    send(1'b1, 8'h11); send(1'b1, 8'h11);
    send(1'b1, 8'h22); send(1'b1, 8'h22);
`ifdef LOADER_CHECKSUM_EN
    send(1'b1, 8'h02);
`endif
    exp_q.push_back(32'hFFFF_1111);
    exp_q.push_back(32'h0000_2222);
    check_writes(1'b1, "wrap");
    check("wrap_done", 32'(b_done_cnt), 32'(d0 + 1));
    check("wrap_err", b_err, 1'b0);

    send(1'b1, 8'h00); send(1'b1, 8'h03); send(1'b1, 8'h55);
    @(negedge clk); #1;
    check("midword_busy", b_busy, 1'b1);
    check("midword_state", b_dbg_state, W_LO);
    check("midword_wdata", b_mem_wdata, 16'h2222);
    b_rst = 1'b1;
    #1;
    check("async_rst_busy", b_busy, 1'b0);
    check("async_rst_wdata", b_mem_wdata, 16'h0000);
    check("async_rst_addr", b_mem_addr, 16'h0000);
    check("async_rst_we", b_mem_we, 1'b0);
    check("async_rst_state", b_dbg_state, IDLE);
    repeat (2) @(posedge clk);
    #1;
    b_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_writes(1'b1, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
